// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, exception
// redirect constants, FSM states and the priority stall encoder.
package pipe_ctrl_pkg;

    localparam int          CNT_W      = 10;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] ERET_CODE  = 32'h0000_000e;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_SETTLE   = 2'd2
    } state_e;

    // The deepest requesting stage wins; it holds itself and everything upstream.
    function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                                input logic req_ex, input logic req_mem);
        logic [5:0] enc;
        if (req_mem == Stop)     enc = STALL_MEM;
        else if (req_ex == Stop) enc = STALL_EX;
        else if (req_id == Stop) enc = STALL_ID;
        else if (req_if == Stop) enc = STALL_IF;
        else                     enc = STALL_NONE;
        return enc;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag that trips one cycle
// after the counter saturates.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    input  logic flush,
    output logic stall_timeout
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush || !stall_active) cnt_d = '0;
        else if (cnt_q != '1)       cnt_d = cnt_q + W'(1);
        timeout_d = timeout_q | (cnt_q == '1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector encoding, exception/ERET flush sequencing
// with deferral behind data-bus waits, and the runaway-stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
);

    state_e      state_q, state_d;
    logic [31:0] exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        exc_live;

    assign exc_live = (excepttype != 32'h0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            exc_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        case (state_q)
            ST_RUN: begin
                if (exc_live && stallreq_mem) begin
                    exc_d   = excepttype;
                    epc_d   = cp0_epc;
                    state_d = ST_WAIT_MEM;
                end else if (exc_live) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_WAIT_MEM: if (!stallreq_mem) state_d = ST_SETTLE;
            ST_SETTLE:   state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = 32'h0;
        case (state_q)
            ST_RUN: begin
                if (exc_live && stallreq_mem) begin
                    stall = STALL_MEM;
                end else if (exc_live) begin
                    flush  = 1'b1;
                    new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
                end else begin
                    stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
                end
            end
            ST_WAIT_MEM: begin
                if (stallreq_mem) begin
                    stall = STALL_MEM;
                end else begin
                    flush  = 1'b1;
                    new_pc = (exc_q == ERET_CODE) ? epc_q : EXC_VECTOR;
                end
            end
            default: ;
        endcase
        if (!rst) begin
            stall  = STALL_NONE;
            flush  = 1'b0;
            new_pc = 32'h0;
        end
    end

    stall_watchdog #(.W(CNT_W)) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall != STALL_NONE),
        .flush        (flush),
        .stall_timeout(stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CMAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0;
    logic [31:0] exc = '0, epc = '0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    // reference model: pending deferred exception, settle cycle, stall run length
    bit          m_pend, m_settle, m_to;
    logic [31:0] m_exc, m_epc;
    int          m_cnt;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .excepttype(exc), .cp0_epc(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .stall_timeout(timeout)
    );

    function automatic logic [5:0] exp_enc(input logic a, b, c, d);
        int h = -1;
        if (a) h = 0;
        if (b) h = 1;
        if (c) h = 2;
        if (d) h = 3;
        if (h < 0) return 6'd0;
        return 6'((1 << (h + 2)) - 1);
    endfunction

    function automatic void model_reset();
        m_pend = 0; m_settle = 0; m_to = 0; m_exc = '0; m_epc = '0; m_cnt = 0;
    endfunction

    // Called at posedge+1; checks combinational outputs mid-cycle, then state after the edge.
    task automatic step(input logic a, b, c, d, input logic [31:0] e, p, input string nm);
        logic [5:0]  es;
        logic        ef;
        logic [31:0] ep;
        sif = a; sid = b; sex = c; smem = d; exc = e; epc = p;
        #3;
        es = 6'd0; ef = 1'b0; ep = 32'h0;
        if (m_settle) begin
        end else if (m_pend) begin
            if (d) es = 6'b011111;
            else begin ef = 1'b1; ep = (m_exc == 32'he) ? m_epc : 32'h20; end
        end else if (e != 0) begin
            if (d) es = 6'b011111;
            else begin ef = 1'b1; ep = (e == 32'he) ? p : 32'h20; end
        end else begin
            es = exp_enc(a, b, c, d);
        end
        checks++;
        if (stall !== es) begin failures++; $display("FAIL %s stall got=%b exp=%b", nm, stall, es); end
        checks++;
        if (flush !== ef) begin failures++; $display("FAIL %s flush got=%b exp=%b", nm, flush, ef); end
        checks++;
        if (new_pc !== ep) begin failures++; $display("FAIL %s new_pc got=%h exp=%h", nm, new_pc, ep); end
        if (m_cnt == CMAX) m_to = 1;
        m_cnt = (es != 0 && !ef) ? ((m_cnt == CMAX) ? CMAX : m_cnt + 1) : 0;
        if (!m_settle && !m_pend && e != 0 && d) begin m_exc = e; m_epc = p; end
        m_pend   = m_settle ? 1'b0 : (m_pend ? d : (e != 0 && d));
        m_settle = ef;
        @(posedge clk); #1;
        checks++;
        if (timeout !== m_to) begin failures++; $display("FAIL %s timeout got=%b exp=%b", nm, timeout, m_to); end
        checks++;
        if (dut.u_watchdog.cnt_q !== CNT_W'(m_cnt)) begin
            failures++; $display("FAIL %s cnt got=%0d exp=%0d", nm, dut.u_watchdog.cnt_q, m_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            sif = 1'($urandom); sid = 1'($urandom); sex = 1'($urandom); smem = 1'($urandom);
            exc = (i % 2 == 0) ? 32'h8 : 32'he; epc = $urandom;
            #3;
            checks++;
            if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin
                failures++; $display("FAIL reset_outputs stall=%b flush=%b new_pc=%h exp all zero", stall, flush, new_pc);
            end
            @(posedge clk); #1;
            checks++;
            if (timeout !== 1'b0 || dut.u_watchdog.cnt_q !== '0) begin
                failures++; $display("FAIL reset_state timeout=%b cnt=%0d exp 0", timeout, dut.u_watchdog.cnt_q);
            end
        end
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, "reset_idle");
    endtask

    task automatic test_stall_encode();
        step(0, 1, 1, 0, 0, 0, "id_ex_1");
        step(0, 1, 1, 0, 0, 0, "id_ex_2");
        checks++;
        if (dut.u_watchdog.cnt_q !== CNT_W'(2)) begin
            failures++; $display("FAIL cnt_after_two got=%0d exp=2", dut.u_watchdog.cnt_q);
        end
        for (int i = 0; i < 60; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, $urandom, "enc_rand");
        step(0, 0, 0, 0, 0, 0, "enc_idle");
    endtask

    task automatic test_exc_free();
        step(0, 0, 0, 0, 32'h8, 32'h1234, "exc_flush");
        step(0, 1, 0, 0, 0, 0, "exc_settle_mask");
        step(0, 1, 0, 0, 0, 0, "exc_after_settle");
        step(0, 0, 0, 0, 0, 0, "exc_idle");
    endtask

    task automatic test_eret_wait();
        step(0, 0, 0, 1, 32'he, 32'h1000, "eret_hold0");
        step(1, 1, 1, 1, 32'h0, 32'h2222, "eret_hold1");
        step(0, 1, 0, 1, 32'h8, 32'h3333, "eret_hold2");
        step(1, 1, 1, 0, 32'h8, 32'h4444, "eret_flush");
        step(1, 1, 1, 1, 32'h8, 32'h5555, "eret_settle");
        step(0, 0, 0, 0, 0, 0, "eret_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] e;
            case ($urandom_range(0, 11))
                0:       e = 32'h8;
                1:       e = 32'he;
                2:       e = $urandom | 32'h1;
                default: e = 32'h0;
            endcase
            step(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                 e, $urandom, "random");
        end
        step(0, 0, 0, 0, 0, 0, "rand_idle");
        step(0, 0, 0, 0, 0, 0, "rand_idle2");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < CMAX + 4; i++) step(0, 0, 1, 0, 0, 0, "timeout_ex");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, "timeout_drop");
        checks++;
        if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", timeout); end
    endtask

    task automatic test_reset_mid_wait();
        step(0, 0, 0, 1, 32'h8, 32'h9999, "rmw_enter");
        sif = 1; sid = 1; sex = 1; smem = 1; exc = 32'h8;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin
            failures++; $display("FAIL rmw_async stall=%b flush=%b new_pc=%h exp all zero", stall, flush, new_pc);
        end
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL rmw_timeout got=%b exp=0", timeout); end
        @(posedge clk); #1;
        smem = 0;
        #3;
        checks++;
        if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'h0) begin
            failures++; $display("FAIL rmw_held stall=%b flush=%b new_pc=%h exp all zero", stall, flush, new_pc);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        step(0, 1, 0, 0, 0, 0, "rmw_no_pending");
        step(0, 0, 0, 0, 0, 0, "rmw_idle");
        step(0, 0, 0, 0, 32'he, 32'h40, "rmw_eret");
        step(0, 0, 0, 0, 0, 0, "rmw_settle");
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_stall_encode();
        test_exc_free();
        test_eret_wait();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage MIPS core. Turns per-stage stall requests into the shared 6-bit `stall` vector consumed by pc_reg and every inter-stage register, including mem_wb. Sequences exception/ERET flushes: a flush is deferred while the memory stage is blocked on the data bus, and stale front-end requests are masked for one cycle afterwards. Also watches for runaway stalls.

## Interface
- `EXC_VECTOR`, 32'h0000_0020: redirect PC for all exceptions except ERET.
- `ERET_CODE`, 32'h0000_000e: `excepttype` value meaning ERET; redirect to `cp0_epc`.
- `CNT_W`, 10: width of the consecutive-stall counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `stallreq_if` input 1: instruction-bus wait.
- `stallreq_id` input 1: load-use hazard.
- `stallreq_ex` input 1: multi-cycle ALU op (div/madd/msub).
- `stallreq_mem` input 1: data-bus wait.
- `excepttype` input 32: exception code of the instruction in MEM; 0 means none.
- `cp0_epc` input 32: current EPC.
- `stall` output 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 means hold.
- `flush` output 1: clear all pipeline registers this cycle.
- `new_pc` output 32: PC to load when `flush`=1; 0 otherwise.
- `stall_timeout` output 1: sticky; set when the counter saturates.

## Operation
- States: RUN, WAIT_MEM, SETTLE. Reset state: RUN.
- Stall encoding, highest stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- RUN:
  - `excepttype`≠0 and `stallreq_mem`=0: `flush`=1 and `stall`=0. `new_pc` = `cp0_epc` if `excepttype`==ERET_CODE, else EXC_VECTOR. Go to SETTLE.
  - `excepttype`≠0 and `stallreq_mem`=1: `stall`=6'b011111, `flush`=0. Capture `excepttype` and `cp0_epc` into holding registers. Go to WAIT_MEM.
  - Otherwise: `stall` per encoding.
- WAIT_MEM:
  - While `stallreq_mem`=1: `stall`=6'b011111, all other requests ignored.
  - First cycle with `stallreq_mem`=0: `flush`=1 and `stall`=0, with `new_pc` computed from the captured values (live inputs ignored). Go to SETTLE.
- SETTLE (exactly one cycle):
  - `stallreq_if` and `stallreq_id` masked, since their sources were just flushed.
  - `stallreq_ex`, `stallreq_mem` and exceptions are also ignored.
  - `stall`=0, `flush`=0. Go to RUN.
- Stall counter (CNT_W bits):
  - Increments on every cycle with `stall`≠0; saturates at all-ones.
  - Clears to 0 on any cycle with `stall`=0 or `flush`=1.
  - `stall_timeout` sets the cycle after the counter reaches all-ones and stays set until reset.
- `flush` and `stall` are never simultaneously nonzero.

## Timing
- `stall`, `flush`, `new_pc` are combinational from state, inputs and holding registers, with zero cycle latency (required for same-cycle load-use stalls).
- State, holding registers, counter and `stall_timeout` are registered.
- Flush latency: 0 cycles from exception if MEM is free; otherwise the first cycle `stallreq_mem` is low.
- `flush` is high for exactly one cycle per exception.
- Reset asserted, including mid-WAIT_MEM: state=RUN, holding registers=0, counter=0, `stall_timeout`=0. While in reset, `stall`=0, `flush`=0, `new_pc`=0, regardless of inputs.

## Structure
- Shared package/define file holds:
  - stall-vector encodings (STALL_NONE/IF/ID/EX/MEM)
  - `Stop`/`NoStop`
  - ERET code
  - exception vector
  - state encodings
- One natural sub-module: `stall_watchdog`, containing the counter and the sticky `stall_timeout`. The FSM and encoder stay in `pipe_ctrl`.

## Test plan
- `stallreq_id`=1 and `stallreq_ex`=1 together -> `stall`=6'b001111 in the same cycle; counter=2 after two cycles.
- `excepttype`=32'h0000_0008, MEM free -> `flush`=1 for one cycle, `new_pc`=32'h20. Next cycle `stallreq_id`=1 is ignored (`stall`=0).
- `excepttype`=ERET_CODE, `cp0_epc`=32'h0000_1000, `stallreq_mem` high for 3 cycles -> `stall`=6'b011111 for 3 cycles, then a 1-cycle flush with `new_pc`=32'h1000, even if `cp0_epc` changes during the wait.
- `stallreq_ex` held for 2^CNT_W cycles -> `stall_timeout` rises and stays high after the request drops.
- Reset asserted asynchronously while in WAIT_MEM -> all outputs 0 immediately. After release, behaviour matches RUN with no pending flush.
